// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding,
// port indices and the supported read-latency ceiling.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic PORT_CPU    = 1'b0;
   localparam logic PORT_AUX    = 1'b1;
   localparam int   MEM_LAT_MAX = 7;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins outright,
// a tie goes to the port that did not win last time.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant_valid,
   output logic       grant_idx
);

   assign grant_valid = |req;
   assign grant_idx   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port data memory. One transaction
// at a time: grant in IDLE, one-cycle command, wait out read latency, then a
// one-cycle done pulse to the winner. Only stall is combinational.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              stall0,
   output logic              stall1,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Out-of-range latencies saturate to the largest the 3-bit counter holds.
   localparam int         LAT_C = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                                  (MEM_LAT < 0) ? 0 : MEM_LAT;
   localparam logic [2:0] LAT3  = 3'(LAT_C);

   state_t     state;
   logic [2:0] cnt;
   logic       last;
   logic       win;
   logic       lat_we;

   logic       grant_valid;
   logic       grant_idx;
   logic       sel_we;

   rr_pick2 u_pick (
      .req         ({req1, req0}),
      .last        (last),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign sel_we = grant_idx ? we1 : we0;

   // Stall is the only combinational output: hold the requester until done.
   assign stall0 = req0 & ~done0;
   assign stall1 = req1 & ~done1;

   // Sequencer FSM. mem_addr/mem_wdata double as the latched request fields,
   // so later changes on addrN/wdataN cannot reach the memory.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= 3'd0;
         last      <= 1'b1;
         win       <= 1'b0;
         lat_we    <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  win       <= grant_idx;
                  last      <= grant_idx;
                  lat_we    <= sel_we;
                  mem_addr  <= grant_idx ? addr1 : addr0;
                  mem_wdata <= grant_idx ? wdata1 : wdata0;
                  mem_read  <= ~sel_we;
                  mem_write <= sel_we;
                  state     <= ST_CMD;
               end
            end
            ST_CMD: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               if (lat_we || LAT_C == 0) begin
                  // Writes finish now; a zero-latency read has its data this cycle.
                  if (!lat_we) begin
                     if (win == PORT_AUX) rdata1 <= mem_rdata;
                     else                 rdata0 <= mem_rdata;
                  end
                  done0 <= (win == PORT_CPU);
                  done1 <= (win == PORT_AUX);
                  state <= ST_DONE;
               end else begin
                  cnt   <= LAT3;
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  if (win == PORT_AUX) rdata1 <= mem_rdata;
                  else                 rdata0 <= mem_rdata;
                  done0 <= (win == PORT_CPU);
                  done1 <= (win == PORT_AUX);
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances at MEM_LAT = 1, 0, 7, each
// with a latency-accurate memory model that returns junk outside its slot.
module tb_mem_arbiter;

   localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

   logic        clk;
   logic [2:0]  rst_n;
   logic [2:0]  req0, req1, we0, we1;
   logic [31:0] addr0 [3];
   logic [31:0] addr1 [3];
   logic [31:0] wdata0 [3];
   logic [31:0] wdata1 [3];
   logic [2:0]  done0, done1, stall0, stall1, mem_read, mem_write;
   logic [31:0] rdata0 [3];
   logic [31:0] rdata1 [3];
   logic [31:0] mem_addr [3];
   logic [31:0] mem_wdata [3];

   int nvec = 0;
   int nerr = 0;
   int port, cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h40)      return 32'hDEAD_BEEF;
      else if (a == 32'h44) return 32'h4444_4444;
      else                  return a ^ 32'hA5A5_0000;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gd
      localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : 7;
      logic        pend;
      int          age;
      logic [31:0] paddr;
      logic [31:0] mrd;

      // Read data appears only L cycles after the command cycle.
      always @(posedge clk or negedge rst_n[g]) begin
         if (!rst_n[g]) begin
            pend  <= 1'b0;
            age   <= 0;
            paddr <= '0;
         end else if (mem_read[g]) begin
            pend  <= 1'b1;
            age   <= 0;
            paddr <= mem_addr[g];
         end else if (pend) begin
            age <= age + 1;
         end
      end

      assign mrd = (L == 0) ? (mem_read[g] ? memf(mem_addr[g]) : JUNK)
                            : ((pend && age == L - 1) ? memf(paddr) : JUNK);

      mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
         .clk       (clk),
         .reset     (rst_n[g]),
         .req0      (req0[g]),
         .req1      (req1[g]),
         .we0       (we0[g]),
         .we1       (we1[g]),
         .addr0     (addr0[g]),
         .addr1     (addr1[g]),
         .wdata0    (wdata0[g]),
         .wdata1    (wdata1[g]),
         .done0     (done0[g]),
         .done1     (done1[g]),
         .rdata0    (rdata0[g]),
         .rdata1    (rdata1[g]),
         .stall0    (stall0[g]),
         .stall1    (stall1[g]),
         .mem_read  (mem_read[g]),
         .mem_write (mem_write[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mrd)
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Advance until instance g pulses a done; cyc = -1 if none within bound.
   task automatic run_to_done(input int g, output int p, output int c);
      p = -1;
      c = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done0[g] | done1[g]) begin
            p = done1[g] ? 1 : 0;
            c = i;
            break;
         end
      end
   endtask

   initial begin
      rst_n = 3'b000;
      req0 = '0; req1 = '0; we0 = '0; we1 = '0;
      for (int i = 0; i < 3; i++) begin
         addr0[i] = '0; addr1[i] = '0; wdata0[i] = '0; wdata1[i] = '0;
      end
      repeat (2) tick();

      // Reset state
      chk("rst_done", {30'd0, done1[0], done0[0]}, 32'd0);
      chk("rst_strobes", {30'd0, mem_write[0], mem_read[0]}, 32'd0);
      chk("rst_mem_addr", mem_addr[0], 32'd0);
      chk("rst_rdata0", rdata0[0], 32'd0);
      chk("rst_rdata1", rdata1[0], 32'd0);
      rst_n = 3'b111;
      tick();

      // Single read, lat 1, port 0 @0x40
      req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 32'h40; #1;
      chk("rd_T_stall0", 32'(stall0[0]), 32'd1);
      chk("rd_T_mem_read", 32'(mem_read[0]), 32'd0);
      tick();
      chk("rd_T1_mem_read", 32'(mem_read[0]), 32'd1);
      chk("rd_T1_mem_addr", mem_addr[0], 32'h40);
      chk("rd_T1_stall0", 32'(stall0[0]), 32'd1);
      tick();
      chk("rd_T2_mem_read", 32'(mem_read[0]), 32'd0);
      chk("rd_T2_done0", 32'(done0[0]), 32'd0);
      chk("rd_T2_stall0", 32'(stall0[0]), 32'd1);
      tick();
      chk("rd_T3_done0", 32'(done0[0]), 32'd1);
      chk("rd_T3_rdata0", rdata0[0], 32'hDEAD_BEEF);
      chk("rd_T3_stall0", 32'(stall0[0]), 32'd0);
      req0[0] = 1'b0;
      tick();
      chk("rd_T4_done0", 32'(done0[0]), 32'd0);

      // Single write, port 1
      req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 32'h80; wdata1[0] = 32'h1234_5678;
      tick();
      chk("wr_T1_mem_write", 32'(mem_write[0]), 32'd1);
      chk("wr_T1_mem_read", 32'(mem_read[0]), 32'd0);
      chk("wr_T1_mem_addr", mem_addr[0], 32'h80);
      chk("wr_T1_mem_wdata", mem_wdata[0], 32'h1234_5678);
      tick();
      chk("wr_T2_done1", 32'(done1[0]), 32'd1);
      chk("wr_T2_mem_write", 32'(mem_write[0]), 32'd0);
      chk("wr_T2_rdata1", rdata1[0], 32'd0);
      req1[0] = 1'b0; we1[0] = 1'b0;
      tick();

      // Contending reads, lat 1: served 0, 1, 0
      addr1[0] = 32'h100; req0[0] = 1'b1; req1[0] = 1'b1;
      run_to_done(0, port, cyc);
      chk("tie1_port", 32'(port), 32'd0);
      chk("tie1_cyc", 32'(cyc), 32'd3);
      run_to_done(0, port, cyc);
      chk("tie2_port", 32'(port), 32'd1);
      chk("tie2_cyc", 32'(cyc), 32'd4);
      chk("tie2_rdata1", rdata1[0], 32'hA5A5_0100);
      run_to_done(0, port, cyc);
      chk("tie3_port", 32'(port), 32'd0);
      chk("tie3_cyc", 32'(cyc), 32'd4);
      req0[0] = 1'b0; req1[0] = 1'b0;
      tick();

      // Reset during WAIT of a port-0 read
      req0[0] = 1'b1;
      tick();
      tick();
      rst_n[0] = 1'b0; #1;
      chk("rstw_done", {30'd0, done1[0], done0[0]}, 32'd0);
      chk("rstw_strobes", {30'd0, mem_write[0], mem_read[0]}, 32'd0);
      chk("rstw_mem_addr", mem_addr[0], 32'd0);
      chk("rstw_rdata0", rdata0[0], 32'd0);
      req0[0] = 1'b0;
      tick();
      chk("rstw_no_done", 32'(done0[0]), 32'd0);
      rst_n[0] = 1'b1;
      tick();
      req0[0] = 1'b1; req1[0] = 1'b1;
      run_to_done(0, port, cyc);
      chk("rstw_tie_port", 32'(port), 32'd0);
      chk("rstw_tie_cyc", 32'(cyc), 32'd3);
      req0[0] = 1'b0; req1[0] = 1'b0;
      tick();

      // MEM_LAT = 0: contending reads, done at T+2 then 3 cycles later
      addr0[1] = 32'h40; addr1[1] = 32'h100; req0[1] = 1'b1; req1[1] = 1'b1;
      run_to_done(1, port, cyc);
      chk("l0_a_port", 32'(port), 32'd0);
      chk("l0_a_cyc", 32'(cyc), 32'd2);
      chk("l0_a_rdata0", rdata0[1], 32'hDEAD_BEEF);
      run_to_done(1, port, cyc);
      chk("l0_b_port", 32'(port), 32'd1);
      chk("l0_b_cyc", 32'(cyc), 32'd3);
      chk("l0_b_rdata1", rdata1[1], 32'hA5A5_0100);
      chk("l0_b_rdata0", rdata0[1], 32'hDEAD_BEEF);
      req0[1] = 1'b0; req1[1] = 1'b0;
      tick();

      // MEM_LAT = 7: addr0 changes during WAIT, done at T+9
      req0[2] = 1'b1; we0[2] = 1'b0; addr0[2] = 32'h40;
      tick();
      chk("l7_T1_mem_read", 32'(mem_read[2]), 32'd1);
      tick();
      addr0[2] = 32'h44;
      tick();
      chk("l7_T3_mem_addr", mem_addr[2], 32'h40);
      chk("l7_T3_done0", 32'(done0[2]), 32'd0);
      run_to_done(2, port, cyc);
      chk("l7_port", 32'(port), 32'd0);
      chk("l7_cyc", 32'(cyc), 32'd6);
      chk("l7_rdata0", rdata0[2], 32'hDEAD_BEEF);
      chk("l7_mem_addr", mem_addr[2], 32'h40);
      req0[2] = 1'b0;
      tick();
      chk("l7_done_end", 32'(done0[2]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port data memory. Port 0 is the CPU load/store path, port 1 is a secondary master such as a DMA or debug loader. The block grants one transaction at a time using round-robin priority, drives the memory command for exactly one cycle, and waits out the memory read latency. It returns the result with a one-cycle `done` pulse and exposes a combinational `stall` per port for pipeline freeze.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 1: read latency of memory in cycles after the command cycle. Legal values are 0 to 7; 0 means combinational read.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted when 0).
- `req0`, `req1`  in  1: transaction request. Held high until the matching `done`.
- `we0`, `we1`  in  1: 1 = write, 0 = read. Stable while `req` is high.
- `addr0`, `addr1`  in  ADDR_W: byte address. Stable while `req` is high.
- `wdata0`, `wdata1`  in  DATA_W: write data. Stable while `req` is high.
- `done0`, `done1`  out  1: one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DATA_W: read result. Valid when `done` is high and the transaction was a read; holds its last value otherwise.
- `stall0`, `stall1`  out  1: combinational `reqN & ~doneN`.
- `mem_read`, `mem_write`  out  1: memory command strobes.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_rdata`  in  DATA_W: memory read data.

## Operation
- FSM states: IDLE, CMD, WAIT, DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - If exactly one `req` is high, grant that port.
  - If both are high, grant the port that is not `last`.
  - On grant: latch `we`, `addr`, `wdata` and the winner index into internal registers; update `last` to the winner; go to CMD.
- CMD:
  - Drive `mem_addr` and `mem_wdata` from the latched values, and assert `mem_read = ~we` or `mem_write = we` for this cycle only.
  - Write: go to DONE.
  - Read with `MEM_LAT = 0`: capture `mem_rdata` at the end of CMD into the winner's `rdata` register; go to DONE.
  - Read with `MEM_LAT > 0`: load the wait counter with `MEM_LAT`; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture `mem_rdata` at the end of that cycle; go to DONE.
  - Counter width is 3 bits.
- DONE:
  - Pulse `done` of the winner for exactly one cycle.
  - Go to IDLE without sampling requests.
- Requests are sampled only in IDLE. A requester may deassert `req` in the cycle after `done` and may re-raise it immediately.
- Withdrawing `req` before `done` is a protocol violation. The transaction still completes and `done` still pulses.
- Changes to `addr`, `wdata` or `we` after the grant have no effect, because the values were latched.
- Only the winning port's `rdata` register updates. The other port's `rdata` is untouched.
- Starvation bound: when both ports are contending, a waiting requester is granted within one transaction.
- Reset state:
  - State is IDLE and the wait counter is 0.
  - `last` = 1, so port 0 wins the first tie.
  - All `done`, `mem_read` and `mem_write` are 0.
  - `mem_addr`, `mem_wdata`, `rdata0` and `rdata1` are 0.
- Reset asserted mid-transaction aborts it immediately: no `done` is issued and command strobes drop asynchronously. A write whose CMD edge has already passed is not rolled back.

## Timing
- With the request first seen in IDLE at cycle T:
  - Command cycle is T+1.
  - Write `done` is at T+2.
  - Read `done` is at T+2+MEM_LAT.
- Back-to-back occupancy per transaction:
  - Writes take 3 cycles, IDLE included.
  - Reads take 3+MEM_LAT cycles.
- Command strobes, `done` and `mem_*` outputs are registered with no combinational path from inputs.
- `stall` is the only combinational output.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state encoding constants (`ST_IDLE`, `ST_CMD`, `ST_WAIT`, `ST_DONE`);
  - port index constants `PORT_CPU = 0` and `PORT_AUX = 1`;
  - `MEM_LAT_MAX = 7`.
- One sub-module is natural: `rr_pick2`, a combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `grant_valid`, `grant_idx`.
- The FSM, latches and counter live in the top module.

## Test plan
- Single read, MEM_LAT=1, memory model returning `0xDEADBEEF` at `0x40`:
  - Stimulus: `req0=1`, `we0=0`, `addr0=0x40` at T.
  - Response: `mem_read` high only at T+1 with `mem_addr=0x40`; `done0` at T+3 with `rdata0=0xDEADBEEF`; `stall0` high T through T+2.
- Single write from port 1:
  - Stimulus: `addr1=0x80`, `wdata1=0x12345678`.
  - Response: `mem_write` one cycle with those values; `done1` at T+2; `rdata1` unchanged.
- Simultaneous requests after reset, both reads:
  - Response: port 0 served first.
  - Then, with both still requesting, port 1 served next; then port 0.
  - `done` alternates 0, 1, 0.
- Same test with MEM_LAT=0 and MEM_LAT=7:
  - Response: read `done` at T+2 and T+9 respectively.
- Reset pulled low during WAIT of a read:
  - Response: no `done`; all outputs 0; first post-reset tie goes to port 0.
- Port 0 changes `addr0` from `0x40` to `0x44` during WAIT:
  - Response: `mem_addr` stays `0x40` and data returned is from `0x40`.
